// File: rtl/mac_pe.sv
// mac_pe: multiply-accumulate processing element for a systolic matrix array.
//
// Operands a (west) and b (north) are forwarded east/south through one
// register stage. When both are valid ("fire"), their product is accumulated
// into a dot product that ends with a_last_i. The finished sum is held in a
// result register until a drain phase shifts it out along the c chain.
//
// Ports:
//   clk, reset_n                    clock, asynchronous active-low reset
//   a_i/a_valid_i/a_last_i          west operand, valid, end-of-dot-product
//   b_i/b_valid_i                   north operand, valid
//   a_o/a_valid_o/a_last_o          registered west operand to east neighbour
//   b_o/b_valid_o                   registered north operand to south neighbour
//   drain_i                         level, result drain phase active
//   c_i/c_valid_i                   result chain from upstream PE
//   c_o/c_valid_o                   result chain to downstream PE
//   ovf_o                           overflow seen in most recently completed result
//   busy_o                          partial sum or product in flight
//   err_o                           sticky: result overwritten before drained
module mac_pe #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 32,
    parameter int SIGNED     = 1,
    parameter int SATURATE   = 1,
    parameter int PIPE_MUL   = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic                  a_valid_i,
    input  logic                  a_last_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    input  logic                  b_valid_i,
    output logic [DATA_WIDTH-1:0] a_o,
    output logic                  a_valid_o,
    output logic                  a_last_o,
    output logic [DATA_WIDTH-1:0] b_o,
    output logic                  b_valid_o,
    input  logic                  drain_i,
    input  logic [ACC_WIDTH-1:0]  c_i,
    input  logic                  c_valid_i,
    output logic [ACC_WIDTH-1:0]  c_o,
    output logic                  c_valid_o,
    output logic                  ovf_o,
    output logic                  busy_o,
    output logic                  err_o
);
    localparam int PW = 2 * DATA_WIDTH;
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic                 fire;
    logic [PW-1:0]        prod_raw;
    logic [ACC_WIDTH-1:0] prod_ext;
    logic                 p_vld, p_last, stage_vld;
    logic [ACC_WIDTH-1:0] p_val;
    logic [0:0]           state;
    logic [ACC_WIDTH-1:0] acc, result, base, sum_w, sat_val, sum_sat;
    logic [ACC_WIDTH:0]   sum_x;
    logic                 acc_ovf, ovf_now, ovf_run, res_valid;
    logic                 drain_q, load;

    assign fire = a_valid_i & b_valid_i;

    // Operand forwarding: unconditional, one cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_o       <= '0;
            a_valid_o <= 1'b0;
            a_last_o  <= 1'b0;
            b_o       <= '0;
            b_valid_o <= 1'b0;
        end else begin
            a_o       <= a_i;
            a_valid_o <= a_valid_i;
            a_last_o  <= a_last_i;
            b_o       <= b_i;
            b_valid_o <= b_valid_i;
        end
    end

    // Full-width product, then sign/zero extension to the accumulator width.
    generate
        if (SIGNED != 0) begin : g_smul
            logic signed [PW-1:0] a_x, b_x;
            assign a_x      = PW'($signed(a_i));
            assign b_x      = PW'($signed(b_i));
            assign prod_raw = a_x * b_x;
            assign prod_ext = ACC_WIDTH'($signed(prod_raw));
        end else begin : g_umul
            assign prod_raw = PW'(a_i) * PW'(b_i);
            assign prod_ext = ACC_WIDTH'(prod_raw);
        end
    endgenerate

    generate
        if (PIPE_MUL != 0) begin : g_pipe
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    p_vld  <= 1'b0;
                    p_last <= 1'b0;
                    p_val  <= '0;
                end else begin
                    p_vld  <= fire;
                    p_last <= fire & a_last_i;
                    if (fire) p_val <= prod_ext;
                end
            end
            assign stage_vld = p_vld;
        end else begin : g_comb
            assign p_vld     = fire;
            assign p_last    = fire & a_last_i;
            assign p_val     = prod_ext;
            assign stage_vld = 1'b0;
        end
    endgenerate

    // In IDLE the base is zero, so the first product loads directly.
    always_comb begin
        base    = (state == ST_RUN) ? acc : '0;
        sum_x   = {1'b0, base} + {1'b0, p_val};
        sum_w   = sum_x[ACC_WIDTH-1:0];
        sat_val = '1;
        ovf_now = sum_x[ACC_WIDTH];
        if (SIGNED != 0) begin
            // Signed overflow: like-signed operands giving an opposite-signed sum.
            ovf_now = (base[ACC_WIDTH-1] == p_val[ACC_WIDTH-1]) &&
                      (sum_w[ACC_WIDTH-1] != base[ACC_WIDTH-1]);
            sat_val = base[ACC_WIDTH-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                        : {1'b0, {(ACC_WIDTH-1){1'b1}}};
        end
        sum_sat = (ovf_now && SATURATE != 0) ? sat_val : sum_w;
        ovf_run = ((state == ST_RUN) & acc_ovf) | ovf_now;
    end

    // Drain load happens on the first cycle of a drain phase.
    assign load = drain_i & ~drain_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            acc       <= '0;
            acc_ovf   <= 1'b0;
            result    <= '0;
            res_valid <= 1'b0;
            ovf_o     <= 1'b0;
            err_o     <= 1'b0;
        end else begin
            if (p_vld) begin
                if (p_last) begin
                    result  <= sum_sat;
                    ovf_o   <= ovf_run;
                    state   <= ST_IDLE;
                    acc_ovf <= 1'b0;
                    // A completing result that lands on the load cycle is safe:
                    // the old one is leaving through the chain.
                    if (res_valid && !load) err_o <= 1'b1;
                end else begin
                    acc     <= sum_sat;
                    acc_ovf <= ovf_run;
                    state   <= ST_RUN;
                end
            end
            res_valid <= (p_vld & p_last) | (res_valid & ~load);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            drain_q   <= 1'b0;
            c_o       <= '0;
            c_valid_o <= 1'b0;
        end else begin
            drain_q <= drain_i;
            if (load) begin
                c_o       <= res_valid ? result : '0;
                c_valid_o <= res_valid;
            end else if (drain_i) begin
                c_o       <= c_i;
                c_valid_o <= c_valid_i;
            end else begin
                c_valid_o <= 1'b0;
            end
        end
    end

    assign busy_o = (state == ST_RUN) | stage_vld;

endmodule

// File: tb/tb_mac_pe.sv
// tb_mac_pe: directed bench for mac_pe across several parameter sets.
// Instances: 0 signed/32/sat/pipe, 1 unsigned/16/sat/pipe,
// 2 unsigned/16/wrap/comb, 3 signed/16/sat/pipe, 4..6 a 3-PE drain chain.
module tb_mac_pe;
    localparam int N = 7;
    localparam int SG  [N] = '{1, 0, 0, 1, 1, 1, 1};
    localparam int W   [N] = '{32, 16, 16, 16, 32, 32, 32};
    localparam int SAT [N] = '{1, 1, 0, 1, 1, 1, 1};

    typedef struct {
        int          k;
        logic [31:0] val;
        logic        ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [7:0]  a [N], b [N], ao [N], bo [N];
    logic        av [N], bv [N], al [N], dr [N];
    logic        avo [N], alo [N], bvo [N], cvo [N], ovf [N], busy [N], err [N];
    logic [31:0] co [N];
    logic [15:0] c16 [1:3];

    // Bench model state
    exp_t   sb [$];
    longint m_acc [N];
    bit     m_run [N], m_ovf [N], m_pend [N], m_err [N];
    int     checks = 0;
    int     errors = 0;

    always #5 clk = ~clk;

`define PE_PORTS(k) .clk(clk), .reset_n(reset_n), .a_i(a[k]), .a_valid_i(av[k]), \
    .a_last_i(al[k]), .b_i(b[k]), .b_valid_i(bv[k]), .a_o(ao[k]), .a_valid_o(avo[k]), \
    .a_last_o(alo[k]), .b_o(bo[k]), .b_valid_o(bvo[k]), .drain_i(dr[k]), \
    .c_valid_o(cvo[k]), .ovf_o(ovf[k]), .busy_o(busy[k]), .err_o(err[k])

    mac_pe #(.SIGNED(1), .ACC_WIDTH(32), .SATURATE(1), .PIPE_MUL(1)) u_pe0 (
        `PE_PORTS(0), .c_i(32'h0), .c_valid_i(1'b0), .c_o(co[0]));
    mac_pe #(.SIGNED(0), .ACC_WIDTH(16), .SATURATE(1), .PIPE_MUL(1)) u_pe1 (
        `PE_PORTS(1), .c_i(16'h0), .c_valid_i(1'b0), .c_o(c16[1]));
    mac_pe #(.SIGNED(0), .ACC_WIDTH(16), .SATURATE(0), .PIPE_MUL(0)) u_pe2 (
        `PE_PORTS(2), .c_i(16'h0), .c_valid_i(1'b0), .c_o(c16[2]));
    mac_pe #(.SIGNED(1), .ACC_WIDTH(16), .SATURATE(1), .PIPE_MUL(1)) u_pe3 (
        `PE_PORTS(3), .c_i(16'h0), .c_valid_i(1'b0), .c_o(c16[3]));
    mac_pe #(.SIGNED(1), .ACC_WIDTH(32), .SATURATE(1), .PIPE_MUL(0)) u_pe4 (
        `PE_PORTS(4), .c_i(32'h0), .c_valid_i(1'b0), .c_o(co[4]));
    mac_pe #(.SIGNED(1), .ACC_WIDTH(32), .SATURATE(1), .PIPE_MUL(0)) u_pe5 (
        `PE_PORTS(5), .c_i(co[4]), .c_valid_i(cvo[4]), .c_o(co[5]));
    mac_pe #(.SIGNED(1), .ACC_WIDTH(32), .SATURATE(1), .PIPE_MUL(0)) u_pe6 (
        `PE_PORTS(6), .c_i(co[5]), .c_valid_i(cvo[5]), .c_o(co[6]));

    assign co[1] = {16'h0, c16[1]};
    assign co[2] = {16'h0, c16[2]};
    assign co[3] = {16'h0, c16[3]};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int find(input int k);
        foreach (sb[i]) if (sb[i].k == k) return i;
        return -1;
    endfunction

    task automatic idle(input int k);
        av[k] = 1'b0;
        bv[k] = 1'b0;
        al[k] = 1'b0;
    endtask

    // Drive one fire into PE k and advance the arithmetic model.
    task automatic feed(input int k, input int x, input int y, input bit last);
        logic [7:0] xa, ya;
        longint pa, pb, base, s, lo, hi, md, span;
        bit o;
        exp_t e;
        xa = x[7:0];
        ya = y[7:0];
        span = 64'sd1 <<< W[k];
        if (SG[k] != 0) begin
            pa = longint'($signed(xa));
            pb = longint'($signed(ya));
            lo = -(span / 2);
            hi = span / 2 - 1;
        end else begin
            pa = longint'(xa);
            pb = longint'(ya);
            lo = 0;
            hi = span - 1;
        end
        base = m_run[k] ? m_acc[k] : 64'sd0;
        s = base + pa * pb;
        o = 1'b0;
        if (s > hi || s < lo) begin
            o = 1'b1;
            if (SAT[k] != 0) s = (s > hi) ? hi : lo;
            else begin
                md = s & (span - 1);
                if (SG[k] != 0 && md > hi) md = md - span;
                s = md;
            end
        end
        if (last) begin
            if (m_pend[k]) begin
                int idx;
                idx = find(k);
                if (idx >= 0) sb.delete(idx);
                m_err[k] = 1'b1;
            end
            e.k   = k;
            e.val = 32'(s & (span - 1));
            e.ovf = m_ovf[k] | o;
            sb.push_back(e);
            m_pend[k] = 1'b1;
            m_run[k]  = 1'b0;
            m_ovf[k]  = 1'b0;
        end else begin
            m_acc[k] = s;
            m_run[k] = 1'b1;
            m_ovf[k] = m_ovf[k] | o;
        end
        a[k]  = xa;
        b[k]  = ya;
        av[k] = 1'b1;
        bv[k] = 1'b1;
        al[k] = last;
        tick();
    endtask

    // Single-PE drain: one load cycle, then drop drain.
    task automatic drain_one(input int k);
        int idx;
        idx = find(k);
        dr[k] = 1'b1;
        tick();
        if (idx >= 0) begin
            check("drain_val", co[k], sb[idx].val);
            check("drain_vld", 32'(cvo[k]), 32'd1);
            check("res_ovf", 32'(ovf[k]), 32'(sb[idx].ovf));
            sb.delete(idx);
        end else begin
            check("drain_none", 32'(cvo[k]), 32'd0);
        end
        m_pend[k] = 1'b0;
        dr[k] = 1'b0;
        tick();
        check("drain_end", 32'(cvo[k]), 32'd0);
    endtask

    initial begin
        reset_n = 1'b0;
        for (int k = 0; k < N; k++) begin
            a[k] = '0; b[k] = '0; av[k] = 1'b0; bv[k] = 1'b0; al[k] = 1'b0; dr[k] = 1'b0;
            m_acc[k] = 0; m_run[k] = 0; m_ovf[k] = 0; m_pend[k] = 0; m_err[k] = 0;
        end
        tick();
        tick();
        check("rst_ao", 32'(ao[0]), 32'd0);
        check("rst_busy", 32'(busy[0]), 32'd0);
        check("rst_err", 32'(err[0]), 32'd0);
        check("rst_cvo", 32'(cvo[6]), 32'd0);
        reset_n = 1'b1;
        tick();

        // Signed pipelined dot product: 3*4 - 2*5 + 7*7 = 51
        feed(0, 3, 4, 0);
        check("fwd_a", 32'(ao[0]), 32'd3);
        check("fwd_b", 32'(bo[0]), 32'd4);
        check("fwd_av", 32'(avo[0]), 32'd1);
        feed(0, -2, 5, 0);
        check("fwd_a2", 32'(ao[0]), 32'hFE);
        feed(0, 7, 7, 1);
        check("fwd_last", 32'(alo[0]), 32'd1);
        check("busy_run", 32'(busy[0]), 32'd1);
        idle(0);
        // Drain load on the completion edge sees no result yet.
        dr[0] = 1'b1;
        tick();
        check("load_early", 32'(cvo[0]), 32'd0);
        check("busy_done", 32'(busy[0]), 32'd0);
        check("no_overrun", 32'(err[0]), 32'd0);
        check("fwd_av_off", 32'(avo[0]), 32'd0);
        dr[0] = 1'b0;
        tick();
        drain_one(0);

        // Unsigned 16-bit saturate (pipelined) and wrap (combinational)
        feed(1, 255, 255, 0);
        feed(1, 255, 255, 1);
        idle(1);
        tick();
        check("usat_ovf", 32'(ovf[1]), 32'd1);
        drain_one(1);
        feed(2, 255, 255, 0);
        feed(2, 255, 255, 1);
        idle(2);
        check("uwrap_ovf", 32'(ovf[2]), 32'd1);
        drain_one(2);

        // Signed 16-bit saturate, then a clean dot product clears ovf
        feed(3, -128, -128, 0);
        feed(3, -128, -128, 1);
        idle(3);
        tick();
        check("ssat_ovf", 32'(ovf[3]), 32'd1);
        drain_one(3);
        feed(3, 1, 1, 1);
        idle(3);
        tick();
        check("ssat_ovf_clr", 32'(ovf[3]), 32'd0);
        drain_one(3);

        // 3-PE chain holding 10, 20, 30
        feed(4, 10, 1, 1); idle(4);
        feed(5, 20, 1, 1); idle(5);
        feed(6, 5, 6, 1);  idle(6);
        tick();
        for (int k = 4; k < N; k++) dr[k] = 1'b1;
        for (int j = 0; j < 3; j++) begin
            int idx;
            tick();
            idx = find(6 - j);
            if (idx >= 0) begin
                check("chain_val", co[6], sb[idx].val);
                sb.delete(idx);
            end
            check("chain_vld", 32'(cvo[6]), 32'd1);
        end
        for (int k = 4; k < N; k++) begin dr[k] = 1'b0; m_pend[k] = 1'b0; end
        tick();
        check("chain_end", 32'(cvo[6]), 32'd0);

        // One-sided valid: forwarded but never accumulated
        a[0] = 8'h5A; av[0] = 1'b1; bv[0] = 1'b0;
        for (int j = 0; j < 4; j++) begin
            tick();
            check("half_busy", 32'(busy[0]), 32'd0);
            check("half_fwd", 32'(avo[0]), 32'd1);
        end
        // Two results without drain: overrun, second held
        feed(0, 2, 2, 1);
        feed(0, 3, 3, 1);
        idle(0);
        tick();
        tick();
        check("overrun", 32'(err[0]), 32'(m_err[0]));
        drain_one(0);

        // Asynchronous reset after two of three fires
        feed(0, 1, 1, 0);
        feed(0, 1, 1, 0);
        idle(0);
        reset_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy[0]), 32'd0);
        check("arst_err", 32'(err[0]), 32'd0);
        check("arst_avo", 32'(avo[0]), 32'd0);
        check("arst_ao", 32'(ao[0]), 32'd0);
        m_run[0] = 0; m_ovf[0] = 0; m_pend[0] = 0; m_err[0] = 0;
        tick();
        reset_n = 1'b1;
        tick();
        feed(0, 2, 3, 1);
        idle(0);
        tick();
        drain_one(0);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
